// File: rtl/lcd_cmd_arbiter_if.sv
// lcd_cmd_arbiter_if: handshake bundle between the two LCD requesters, the arbiter and the
// lcd_interface command port.
//   i_req_valid/i_req_rs/i_req_last [1:0] : per-requester beat valid, RS bit, end-of-burst
//   i_req_data0/i_req_data1 [7:0]          : requester 0 / requester 1 beat byte
//   o_req_ready [1:0]                      : per-requester beat accept
//   o_grant [1:0]                          : one-hot burst grant, 0 when idle
//   o_lcd_valid/o_lcd_rs/o_lcd_data        : registered beat toward lcd_interface
//   i_lcd_ready                            : lcd_interface consumes the pending beat
//   o_abort [1:0]                          : one-cycle pulse when a stalled grant is revoked
//   o_busy                                 : burst in progress or beat pending
// The slave modport is the arbiter; the master modport is the surrounding logic.
interface lcd_cmd_arbiter_if;
  logic [1:0] i_req_valid;
  logic [1:0] i_req_rs;
  logic [7:0] i_req_data0;
  logic [7:0] i_req_data1;
  logic [1:0] i_req_last;
  logic [1:0] o_req_ready;
  logic [1:0] o_grant;
  logic       o_lcd_valid;
  logic       o_lcd_rs;
  logic [7:0] o_lcd_data;
  logic       i_lcd_ready;
  logic [1:0] o_abort;
  logic       o_busy;

  modport slave (
    input  i_req_valid, i_req_rs, i_req_data0, i_req_data1, i_req_last, i_lcd_ready,
    output o_req_ready, o_grant, o_lcd_valid, o_lcd_rs, o_lcd_data, o_abort, o_busy
  );

  modport master (
    output i_req_valid, i_req_rs, i_req_data0, i_req_data1, i_req_last, i_lcd_ready,
    input  o_req_ready, o_grant, o_lcd_valid, o_lcd_rs, o_lcd_data, o_abort, o_busy
  );
endinterface

// File: rtl/lcd_cmd_arbiter.sv
// lcd_cmd_arbiter: shares the lcd_interface command port between the time/date refresh path
// (requester 0) and the alarm/menu editor (requester 1). Whole bursts (set-address command plus
// characters, ended by last) are granted round-robin so cursor moves and text never interleave.
// Each accepted beat lands in a one-deep output register. A grant whose requester leaves valid
// low for TIMEOUT cycles mid-burst is revoked with an abort pulse.
// Ports:
//   sys_clk   : system clock
//   sys_rst_n : asynchronous active-low reset
//   bus       : lcd_cmd_arbiter_if.slave, requester and lcd_interface handshakes
module lcd_cmd_arbiter #(
  parameter int unsigned TIMEOUT = 1000
) (
  input logic               sys_clk,
  input logic               sys_rst_n,
  lcd_cmd_arbiter_if.slave  bus
);

  typedef enum logic {StIdle, StBurst} state_e;

  localparam logic [15:0] StallMax = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        g_q, g_d;
  logic        last_grant_q;
  logic [15:0] cnt_q, cnt_d;
  logic        lcd_valid_q;
  logic        lcd_rs_q;
  logic [7:0]  lcd_data_q;
  logic [1:0]  abort_q;

  logic       req_valid_g;
  logic       req_rs_g;
  logic       req_last_g;
  logic [7:0] req_data_g;
  logic       ready_g;
  logic       accept;
  logic       burst_end;
  logic       stall_timeout;

  // Granted requester's beat; the other requester is ignored during a burst.
  assign req_valid_g = bus.i_req_valid[g_q];
  assign req_rs_g    = bus.i_req_rs[g_q];
  assign req_last_g  = bus.i_req_last[g_q];
  assign req_data_g  = g_q ? bus.i_req_data1 : bus.i_req_data0;

  assign ready_g       = (state_q == StBurst) && (!lcd_valid_q || bus.i_lcd_ready);
  assign accept        = ready_g && req_valid_g;
  assign burst_end     = accept && req_last_g;
  assign stall_timeout = (state_q == StBurst) && !req_valid_g && (cnt_q == StallMax);

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and grant selection
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    unique case (state_q)
      StIdle: begin
        if (|bus.i_req_valid) begin
          state_d = StBurst;
          // On a tie the requester that did not hold the last grant wins.
          g_d = (&bus.i_req_valid) ? ~last_grant_q : bus.i_req_valid[1];
        end
      end
      StBurst: begin
        if (burst_end || stall_timeout) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    bus.o_grant     = 2'b00;
    bus.o_req_ready = 2'b00;
    if (state_q == StBurst) begin
      bus.o_grant[g_q]     = 1'b1;
      bus.o_req_ready[g_q] = ready_g;
    end
    bus.o_busy = (state_q != StIdle) || lcd_valid_q;
  end

  // Stall counter: zero while idle so every burst starts fresh, cleared on each accepted beat,
  // advances only while the granted requester has nothing to offer.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = '0;
    end else if (!req_valid_g) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      g_q          <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      abort_q      <= 2'b00;
      lcd_valid_q  <= 1'b0;
      lcd_rs_q     <= 1'b0;
      lcd_data_q   <= 8'h00;
    end else begin
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      abort_q <= stall_timeout ? (2'b01 << g_q) : 2'b00;
      if (burst_end || stall_timeout) begin
        last_grant_q <= g_q;
      end
      // A beat already registered survives a timeout and is still delivered.
      if (accept) begin
        lcd_valid_q <= 1'b1;
        lcd_rs_q    <= req_rs_g;
        lcd_data_q  <= req_data_g;
      end else if (bus.i_lcd_ready) begin
        lcd_valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_lcd_valid = lcd_valid_q;
  assign bus.o_lcd_rs    = lcd_rs_q;
  assign bus.o_lcd_data  = lcd_data_q;
  assign bus.o_abort     = abort_q;

endmodule
